// File: rtl/icb_nmms_bus.sv
// icb_nmms_bus: N-master / M-slave ICB interconnect with round-robin arbitration, decode-miss and accept-timeout errors.
// Latency: 1 arbitration cycle, then cmd and rsp pass combinationally; 3 cycles minimum, one transaction outstanding.
// Backpressure: slave cmd_ready and master rsp_ready pass straight through to the granted pair; everyone else sees 0.
module icb_nmms_bus #(
    parameter int M_NUM   = 2,
    parameter int S_NUM   = 8,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SEL_MSB = 31,
    parameter int SEL_LSB = 28,
    parameter int TMO     = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [M_NUM-1:0]       m_icb_cmd_valid,
    output logic [M_NUM-1:0]       m_icb_cmd_ready,
    input  logic [M_NUM*AW-1:0]    m_icb_cmd_addr,
    input  logic [M_NUM-1:0]       m_icb_cmd_read,
    input  logic [M_NUM*DW-1:0]    m_icb_cmd_wdata,
    input  logic [M_NUM*DW/8-1:0]  m_icb_cmd_wmask,
    output logic [M_NUM-1:0]       m_icb_rsp_valid,
    input  logic [M_NUM-1:0]       m_icb_rsp_ready,
    output logic [M_NUM-1:0]       m_icb_rsp_err,
    output logic [M_NUM*DW-1:0]    m_icb_rsp_rdata,
    output logic [S_NUM-1:0]       s_icb_cmd_valid,
    input  logic [S_NUM-1:0]       s_icb_cmd_ready,
    output logic [AW-1:0]          s_icb_cmd_addr,
    output logic                   s_icb_cmd_read,
    output logic [DW-1:0]          s_icb_cmd_wdata,
    output logic [DW/8-1:0]        s_icb_cmd_wmask,
    input  logic [S_NUM-1:0]       s_icb_rsp_valid,
    output logic [S_NUM-1:0]       s_icb_rsp_ready,
    input  logic [S_NUM-1:0]       s_icb_rsp_err,
    input  logic [S_NUM*DW-1:0]    s_icb_rsp_rdata,
    output logic                   bus_busy,
    output logic                   tmo_pulse
);

    localparam int MW = (M_NUM > 1) ? $clog2(M_NUM) : 1;
    localparam int SW = SEL_MSB - SEL_LSB + 1;
    localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam int BW = DW / 8;

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_RSP, ST_DERR, ST_ERSP} state_t;

    state_t          state, state_nxt;
    logic [MW-1:0]   gnt, gnt_nxt, rr_ptr, rr_nxt, gnt_inc;
    logic [SW-1:0]   sel, sel_nxt;
    logic [TW-1:0]   timer;

    logic            arb_hit;
    logic [MW-1:0]   arb_idx;
    logic [SW-1:0]   arb_sel;
    logic            sel_ok;
    logic            tmo_hit;

    logic            g_valid, g_read, g_rsp_ready;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_wdata;
    logic [BW-1:0]   g_wmask;
    logic            sl_cmd_ready, sl_rsp_valid, sl_rsp_err;
    logic [DW-1:0]   sl_rsp_rdata;

    // Round-robin pick: first requester at or above rr_ptr, otherwise first requester from 0 (wrap).
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int m = 0; m < M_NUM; m++) begin
            if (!arb_hit && m_icb_cmd_valid[m] && (MW'(m) >= rr_ptr)) begin
                arb_hit = 1'b1;
                arb_idx = MW'(m);
            end
        end
        for (int m = 0; m < M_NUM; m++) begin
            if (!arb_hit && m_icb_cmd_valid[m]) begin
                arb_hit = 1'b1;
                arb_idx = MW'(m);
            end
        end
        arb_sel = '0;
        for (int m = 0; m < M_NUM; m++) begin
            if (arb_idx == MW'(m)) arb_sel = m_icb_cmd_addr[m*AW + SEL_LSB +: SW];
        end
        sel_ok = (32'(arb_sel) < 32'(S_NUM));
    end

    // Mux out the granted master's command and response-ready, and the selected slave's signals.
    always_comb begin
        g_valid     = 1'b0;
        g_read      = 1'b0;
        g_addr      = '0;
        g_wdata     = '0;
        g_wmask     = '0;
        g_rsp_ready = 1'b0;
        for (int m = 0; m < M_NUM; m++) begin
            if (gnt == MW'(m)) begin
                g_valid     = m_icb_cmd_valid[m];
                g_read      = m_icb_cmd_read[m];
                g_addr      = m_icb_cmd_addr[m*AW +: AW];
                g_wdata     = m_icb_cmd_wdata[m*DW +: DW];
                g_wmask     = m_icb_cmd_wmask[m*BW +: BW];
                g_rsp_ready = m_icb_rsp_ready[m];
            end
        end
        sl_cmd_ready = 1'b0;
        sl_rsp_valid = 1'b0;
        sl_rsp_err   = 1'b0;
        sl_rsp_rdata = '0;
        for (int s = 0; s < S_NUM; s++) begin
            if (sel == SW'(s)) begin
                sl_cmd_ready = s_icb_cmd_ready[s];
                sl_rsp_valid = s_icb_rsp_valid[s];
                sl_rsp_err   = s_icb_rsp_err[s];
                sl_rsp_rdata = s_icb_rsp_rdata[s*DW +: DW];
            end
        end
    end

    // Timeout fires on the CMD cycle where the timer has counted TMO cycles; TMO=0 never fires.
    assign tmo_hit = (TMO != 0) && (state == ST_CMD) && (timer == TW'(TMO));
    assign gnt_inc = (gnt == MW'(M_NUM - 1)) ? '0 : gnt + 1'b1;

    // State register with grant, slave select and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            gnt    <= '0;
            sel    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            sel    <= sel_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    // Accept timer: counts CMD cycles, saturates at TMO, cleared outside CMD.
    always_ff @(posedge clk) begin
        if (rst || state != ST_CMD) timer <= '0;
        else if (timer != TW'(TMO)) timer <= timer + 1'b1;
    end

    // Next-state logic: arbitrate in IDLE, advance on handshakes, pointer moves past the finished master.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        rr_nxt    = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (arb_hit) begin
                    gnt_nxt   = arb_idx;
                    sel_nxt   = arb_sel;
                    state_nxt = sel_ok ? ST_CMD : ST_DERR;
                end
            end
            ST_CMD: begin
                if (tmo_hit) state_nxt = ST_ERSP;
                else if (g_valid && sl_cmd_ready) state_nxt = ST_RSP;
            end
            ST_RSP: begin
                if (sl_rsp_valid && g_rsp_ready) begin
                    rr_nxt    = gnt_inc;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DERR: state_nxt = ST_ERSP;
            ST_ERSP: begin
                if (g_rsp_ready) begin
                    rr_nxt    = gnt_inc;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: only the granted master and selected slave ever see non-zero signals.
    always_comb begin
        m_icb_cmd_ready = '0;
        m_icb_rsp_valid = '0;
        m_icb_rsp_err   = '0;
        m_icb_rsp_rdata = '0;
        s_icb_cmd_valid = '0;
        s_icb_cmd_addr  = '0;
        s_icb_cmd_read  = 1'b0;
        s_icb_cmd_wdata = '0;
        s_icb_cmd_wmask = '0;
        s_icb_rsp_ready = '0;
        bus_busy        = (state != ST_IDLE);
        tmo_pulse       = tmo_hit;
        case (state)
            ST_CMD: begin
                s_icb_cmd_addr  = g_addr;
                s_icb_cmd_read  = g_read;
                s_icb_cmd_wdata = g_wdata;
                s_icb_cmd_wmask = g_wmask;
                for (int s = 0; s < S_NUM; s++)
                    if (sel == SW'(s)) s_icb_cmd_valid[s] = g_valid && !tmo_hit;
                for (int m = 0; m < M_NUM; m++)
                    if (gnt == MW'(m)) m_icb_cmd_ready[m] = tmo_hit || sl_cmd_ready;
            end
            ST_RSP: begin
                for (int m = 0; m < M_NUM; m++) begin
                    if (gnt == MW'(m)) begin
                        m_icb_rsp_valid[m]          = sl_rsp_valid;
                        m_icb_rsp_err[m]            = sl_rsp_err;
                        m_icb_rsp_rdata[m*DW +: DW] = sl_rsp_rdata;
                    end
                end
                for (int s = 0; s < S_NUM; s++)
                    if (sel == SW'(s)) s_icb_rsp_ready[s] = g_rsp_ready;
            end
            ST_DERR: begin
                for (int m = 0; m < M_NUM; m++)
                    if (gnt == MW'(m)) m_icb_cmd_ready[m] = 1'b1;
            end
            ST_ERSP: begin
                for (int m = 0; m < M_NUM; m++) begin
                    if (gnt == MW'(m)) begin
                        m_icb_rsp_valid[m] = 1'b1;
                        m_icb_rsp_err[m]   = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icb_nmms_bus.sv
// tb_icb_nmms_bus: directed bench for the ICB interconnect, 2 masters / 5 slaves / TMO=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Each scenario task starts from a clean reset and checks its own expectations inline.
module tb_icb_nmms_bus;

    localparam int M_NUM = 2;
    localparam int S_NUM = 5;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int TMO   = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [M_NUM-1:0]      m_icb_cmd_valid;
    logic [M_NUM-1:0]      m_icb_cmd_ready;
    logic [M_NUM*AW-1:0]   m_icb_cmd_addr;
    logic [M_NUM-1:0]      m_icb_cmd_read;
    logic [M_NUM*DW-1:0]   m_icb_cmd_wdata;
    logic [M_NUM*DW/8-1:0] m_icb_cmd_wmask;
    logic [M_NUM-1:0]      m_icb_rsp_valid;
    logic [M_NUM-1:0]      m_icb_rsp_ready;
    logic [M_NUM-1:0]      m_icb_rsp_err;
    logic [M_NUM*DW-1:0]   m_icb_rsp_rdata;
    logic [S_NUM-1:0]      s_icb_cmd_valid;
    logic [S_NUM-1:0]      s_icb_cmd_ready;
    logic [AW-1:0]         s_icb_cmd_addr;
    logic                  s_icb_cmd_read;
    logic [DW-1:0]         s_icb_cmd_wdata;
    logic [DW/8-1:0]       s_icb_cmd_wmask;
    logic [S_NUM-1:0]      s_icb_rsp_valid;
    logic [S_NUM-1:0]      s_icb_rsp_ready;
    logic [S_NUM-1:0]      s_icb_rsp_err;
    logic [S_NUM*DW-1:0]   s_icb_rsp_rdata;
    logic                  bus_busy;
    logic                  tmo_pulse;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    icb_nmms_bus #(
        .M_NUM(M_NUM), .S_NUM(S_NUM), .AW(AW), .DW(DW),
        .SEL_MSB(31), .SEL_LSB(28), .TMO(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
        .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
        .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
        .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready),
        .m_icb_rsp_err(m_icb_rsp_err), .m_icb_rsp_rdata(m_icb_rsp_rdata),
        .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
        .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
        .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
        .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
        .s_icb_rsp_err(s_icb_rsp_err), .s_icb_rsp_rdata(s_icb_rsp_rdata),
        .bus_busy(bus_busy), .tmo_pulse(tmo_pulse)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic quiet();
        m_icb_cmd_valid = '0;
        m_icb_cmd_addr  = '0;
        m_icb_cmd_read  = '0;
        m_icb_cmd_wdata = '0;
        m_icb_cmd_wmask = '0;
        m_icb_rsp_ready = '0;
        s_icb_cmd_ready = '0;
        s_icb_rsp_valid = '0;
        s_icb_rsp_err   = '0;
        s_icb_rsp_rdata = '0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        quiet();
        rst = 1'b1;
        m_icb_cmd_valid = 2'b11;
        m_icb_cmd_addr  = {32'h1000_0000, 32'h2000_0000};
        s_icb_cmd_ready = '1;
        cyc();
        cyc();
        mid();
        tests++;
        if ({m_icb_cmd_ready, m_icb_rsp_valid, m_icb_rsp_err, s_icb_cmd_valid, s_icb_rsp_ready, bus_busy, tmo_pulse} !== 18'h0) begin
            fails++;
            $display("FAIL reset_ctrl: got cmd_rdy=%b rsp_vld=%b err=%b s_vld=%b s_rrdy=%b busy=%b tmo=%b, expected all 0",
                     m_icb_cmd_ready, m_icb_rsp_valid, m_icb_rsp_err, s_icb_cmd_valid, s_icb_rsp_ready, bus_busy, tmo_pulse);
        end
        tests++;
        if ({m_icb_rsp_rdata, s_icb_cmd_addr, s_icb_cmd_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h, expected 0", m_icb_rsp_rdata, s_icb_cmd_addr, s_icb_cmd_wdata);
        end
        cyc();
        rst = 1'b0;
        quiet();
    endtask

    task automatic test_single_read();
        do_reset();
        m_icb_cmd_valid = 2'b10;
        m_icb_cmd_addr[AW +: AW] = 32'h2000_0010;
        m_icb_cmd_read  = 2'b10;
        s_icb_cmd_ready = 5'b00100;
        mid();
        tests++;
        if ({m_icb_cmd_ready, bus_busy} !== 3'b000) begin
            fails++;
            $display("FAIL single_idle: got cmd_rdy=%b busy=%b, expected 00 0", m_icb_cmd_ready, bus_busy);
        end
        cyc();
        mid();
        tests++;
        if ({s_icb_cmd_valid, m_icb_cmd_ready} !== {5'b00100, 2'b10}) begin
            fails++;
            $display("FAIL single_cmd: got s_vld=%b cmd_rdy=%b, expected 00100 10", s_icb_cmd_valid, m_icb_cmd_ready);
        end
        tests++;
        if ({s_icb_cmd_addr, s_icb_cmd_read} !== {32'h2000_0010, 1'b1}) begin
            fails++;
            $display("FAIL single_addr: got addr=%h read=%b, expected 20000010 1", s_icb_cmd_addr, s_icb_cmd_read);
        end
        cyc();
        m_icb_cmd_valid = '0;
        s_icb_rsp_valid = 5'b00100;
        s_icb_rsp_rdata[2*DW +: DW] = 32'hDEAD_BEEF;
        m_icb_rsp_ready = 2'b10;
        mid();
        tests++;
        if ({m_icb_rsp_valid, m_icb_rsp_err, s_icb_rsp_ready} !== {2'b10, 2'b00, 5'b00100}) begin
            fails++;
            $display("FAIL single_rsp: got rsp_vld=%b err=%b s_rrdy=%b, expected 10 00 00100", m_icb_rsp_valid, m_icb_rsp_err, s_icb_rsp_ready);
        end
        tests++;
        if (m_icb_rsp_rdata !== {32'hDEAD_BEEF, 32'h0}) begin
            fails++;
            $display("FAIL single_rdata: got %h, expected deadbeef00000000", m_icb_rsp_rdata);
        end
        cyc();
        mid();
        tests++;
        if ({bus_busy, m_icb_rsp_valid} !== 3'b000) begin
            fails++;
            $display("FAIL single_done: got busy=%b rsp_vld=%b after 3 cycles, expected 0 00", bus_busy, m_icb_rsp_valid);
        end
        quiet();
    endtask

    task automatic test_contention();
        int n  = 0;
        int c0 = 0;
        int c1 = 0;
        do_reset();
        m_icb_cmd_valid = 2'b11;
        m_icb_cmd_addr  = {32'h3000_0000, 32'h1000_0000};
        m_icb_cmd_read  = 2'b11;
        m_icb_rsp_ready = 2'b11;
        s_icb_cmd_ready = '1;
        s_icb_rsp_valid = '1;
        s_icb_rsp_rdata[1*DW +: DW] = 32'h1111_1111;
        s_icb_rsp_rdata[3*DW +: DW] = 32'h3333_3333;
        for (int i = 0; i < 24; i++) begin
            mid();
            if (m_icb_rsp_valid != 2'b00) begin
                tests++;
                if ((n % 2) == 0) begin
                    if ({m_icb_rsp_valid, m_icb_rsp_rdata[0 +: DW]} !== {2'b01, 32'h1111_1111}) begin
                        fails++;
                        $display("FAIL contention_grant%0d: got rsp_vld=%b rdata0=%h, expected 01 11111111", n, m_icb_rsp_valid, m_icb_rsp_rdata[0 +: DW]);
                    end
                end else begin
                    if ({m_icb_rsp_valid, m_icb_rsp_rdata[DW +: DW]} !== {2'b10, 32'h3333_3333}) begin
                        fails++;
                        $display("FAIL contention_grant%0d: got rsp_vld=%b rdata1=%h, expected 10 33333333", n, m_icb_rsp_valid, m_icb_rsp_rdata[DW +: DW]);
                    end
                end
                if (m_icb_rsp_valid[0]) c0++;
                if (m_icb_rsp_valid[1]) c1++;
                n++;
            end
            cyc();
        end
        tests++;
        if (n != 8 || c0 != 4 || c1 != 4) begin
            fails++;
            $display("FAIL contention_count: got %0d transfers (m0=%0d m1=%0d), expected 8 (4/4)", n, c0, c1);
        end
        quiet();
    endtask

    task automatic test_decode_miss();
        do_reset();
        s_icb_cmd_ready = '1;
        s_icb_rsp_valid = '1;
        s_icb_rsp_rdata = {5{32'hA5A5_A5A5}};
        m_icb_cmd_valid = 2'b01;
        m_icb_cmd_addr[0 +: AW] = 32'h7000_0000;
        m_icb_cmd_read  = 2'b01;
        cyc();
        mid();
        tests++;
        if ({m_icb_cmd_ready, s_icb_cmd_valid} !== {2'b01, 5'b00000}) begin
            fails++;
            $display("FAIL derr_accept: got cmd_rdy=%b s_vld=%b, expected 01 00000", m_icb_cmd_ready, s_icb_cmd_valid);
        end
        cyc();
        m_icb_cmd_valid = '0;
        m_icb_rsp_ready = 2'b01;
        mid();
        tests++;
        if ({m_icb_cmd_ready, m_icb_rsp_valid, m_icb_rsp_err, s_icb_cmd_valid, s_icb_rsp_ready} !== {2'b00, 2'b01, 2'b01, 5'b0, 5'b0}) begin
            fails++;
            $display("FAIL derr_rsp: got cmd_rdy=%b rsp_vld=%b err=%b s_vld=%b s_rrdy=%b, expected 00 01 01 00000 00000",
                     m_icb_cmd_ready, m_icb_rsp_valid, m_icb_rsp_err, s_icb_cmd_valid, s_icb_rsp_ready);
        end
        tests++;
        if (m_icb_rsp_rdata !== '0) begin
            fails++;
            $display("FAIL derr_rdata: got %h, expected 0", m_icb_rsp_rdata);
        end
        cyc();
        mid();
        tests++;
        if (bus_busy !== 1'b0) begin
            fails++;
            $display("FAIL derr_done: got busy=%b, expected 0", bus_busy);
        end
        quiet();
    endtask

    task automatic test_timeout();
        do_reset();
        m_icb_cmd_valid = 2'b01;
        m_icb_cmd_addr[0 +: AW] = 32'h1000_0000;
        m_icb_cmd_wdata[0 +: DW] = 32'h0000_0055;
        m_icb_cmd_wmask[0 +: 4]  = 4'hF;
        cyc();
        for (int k = 0; k < TMO; k++) begin
            mid();
            tests++;
            if ({s_icb_cmd_valid, m_icb_cmd_ready, tmo_pulse} !== {5'b00010, 2'b00, 1'b0}) begin
                fails++;
                $display("FAIL tmo_wait%0d: got s_vld=%b cmd_rdy=%b tmo=%b, expected 00010 00 0", k, s_icb_cmd_valid, m_icb_cmd_ready, tmo_pulse);
            end
            cyc();
        end
        mid();
        tests++;
        if ({s_icb_cmd_valid, m_icb_cmd_ready, tmo_pulse} !== {5'b00000, 2'b01, 1'b1}) begin
            fails++;
            $display("FAIL tmo_fire: got s_vld=%b cmd_rdy=%b tmo=%b, expected 00000 01 1", s_icb_cmd_valid, m_icb_cmd_ready, tmo_pulse);
        end
        cyc();
        m_icb_cmd_valid = '0;
        m_icb_rsp_ready = 2'b01;
        mid();
        tests++;
        if ({m_icb_rsp_valid, m_icb_rsp_err, tmo_pulse} !== {2'b01, 2'b01, 1'b0}) begin
            fails++;
            $display("FAIL tmo_rsp: got rsp_vld=%b err=%b tmo=%b, expected 01 01 0", m_icb_rsp_valid, m_icb_rsp_err, tmo_pulse);
        end
        cyc();
        mid();
        tests++;
        if (bus_busy !== 1'b0) begin
            fails++;
            $display("FAIL tmo_done: got busy=%b, expected 0", bus_busy);
        end
        quiet();
    endtask

    task automatic test_backpressure();
        do_reset();
        s_icb_cmd_ready = '1;
        m_icb_cmd_valid = 2'b01;
        m_icb_cmd_addr[0 +: AW] = 32'h3000_0004;
        m_icb_cmd_read  = 2'b01;
        cyc();
        cyc();
        m_icb_cmd_valid = '0;
        s_icb_rsp_valid = 5'b01000;
        s_icb_rsp_rdata[3*DW +: DW] = 32'h1234_5678;
        m_icb_rsp_ready = '0;
        for (int k = 0; k < 3; k++) begin
            mid();
            tests++;
            if ({m_icb_rsp_valid, s_icb_rsp_ready, bus_busy, m_icb_rsp_rdata[0 +: DW]} !== {2'b01, 5'b00000, 1'b1, 32'h1234_5678}) begin
                fails++;
                $display("FAIL bp_hold%0d: got rsp_vld=%b s_rrdy=%b busy=%b rdata0=%h, expected 01 00000 1 12345678",
                         k, m_icb_rsp_valid, s_icb_rsp_ready, bus_busy, m_icb_rsp_rdata[0 +: DW]);
            end
            cyc();
        end
        m_icb_rsp_ready = 2'b01;
        mid();
        tests++;
        if ({m_icb_rsp_valid, s_icb_rsp_ready} !== {2'b01, 5'b01000}) begin
            fails++;
            $display("FAIL bp_release: got rsp_vld=%b s_rrdy=%b, expected 01 01000", m_icb_rsp_valid, s_icb_rsp_ready);
        end
        cyc();
        mid();
        tests++;
        if (bus_busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_done: got busy=%b, expected 0", bus_busy);
        end
        quiet();
    endtask

    task automatic test_reset_mid_rsp();
        do_reset();
        s_icb_cmd_ready = '1;
        m_icb_cmd_valid = 2'b01;
        m_icb_cmd_addr[0 +: AW] = 32'h2000_0000;
        m_icb_cmd_read  = 2'b01;
        cyc();
        cyc();
        m_icb_cmd_valid = '0;
        s_icb_rsp_valid = 5'b00100;
        s_icb_rsp_rdata[2*DW +: DW] = 32'hBEEF_0001;
        mid();
        tests++;
        if (m_icb_rsp_valid !== 2'b01) begin
            fails++;
            $display("FAIL rstrsp_inrsp: got rsp_vld=%b, expected 01", m_icb_rsp_valid);
        end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mid();
        tests++;
        if ({m_icb_cmd_ready, m_icb_rsp_valid, m_icb_rsp_err, s_icb_cmd_valid, s_icb_rsp_ready, bus_busy, tmo_pulse} !== 18'h0
            || m_icb_rsp_rdata !== '0) begin
            fails++;
            $display("FAIL rstrsp_clear: got rsp_vld=%b s_rrdy=%b busy=%b rdata=%h, expected all 0",
                     m_icb_rsp_valid, s_icb_rsp_ready, bus_busy, m_icb_rsp_rdata);
        end
        cyc();
        quiet();
        s_icb_cmd_ready = '1;
        s_icb_rsp_valid = 5'b00010;
        m_icb_rsp_ready = 2'b01;
        m_icb_cmd_valid = 2'b01;
        m_icb_cmd_addr[0 +: AW]  = 32'h1000_0020;
        m_icb_cmd_wdata[0 +: DW] = 32'hCAFE_F00D;
        m_icb_cmd_wmask[0 +: 4]  = 4'hC;
        cyc();
        mid();
        tests++;
        if ({s_icb_cmd_valid, s_icb_cmd_read, s_icb_cmd_addr, s_icb_cmd_wdata, s_icb_cmd_wmask}
            !== {5'b00010, 1'b0, 32'h1000_0020, 32'hCAFE_F00D, 4'hC}) begin
            fails++;
            $display("FAIL rstrsp_write_cmd: got s_vld=%b rd=%b addr=%h wdata=%h wmask=%h, expected 00010 0 10000020 cafef00d c",
                     s_icb_cmd_valid, s_icb_cmd_read, s_icb_cmd_addr, s_icb_cmd_wdata, s_icb_cmd_wmask);
        end
        cyc();
        m_icb_cmd_valid = '0;
        mid();
        tests++;
        if ({m_icb_rsp_valid, m_icb_rsp_err} !== {2'b01, 2'b00}) begin
            fails++;
            $display("FAIL rstrsp_write_rsp: got rsp_vld=%b err=%b, expected 01 00", m_icb_rsp_valid, m_icb_rsp_err);
        end
        cyc();
        mid();
        tests++;
        if (bus_busy !== 1'b0) begin
            fails++;
            $display("FAIL rstrsp_write_done: got busy=%b, expected 0", bus_busy);
        end
        quiet();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        quiet();
        test_reset();
        test_single_read();
        test_contention();
        test_decode_miss();
        test_timeout();
        test_backpressure();
        test_reset_mid_rsp();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/icb_nmms_bus.md
Name: icb_nmms_bus

Overview:
- Parametrised N-master / M-slave ICB interconnect for the SoC fabric.
- Successor to the fixed 2-master/8-slave bridge, generalised in master count, slave count and decode field.
- Adds round-robin arbitration, decode-miss error response, and a slave-accept timeout.
- Sits between bus masters (JTAG DM, core) and slaves (iram, sram, sysp, plic, sdrd, ...).
- Single outstanding transaction system-wide.

Parameters:
- M_NUM, 2, number of masters (1..8).
- S_NUM, 8, number of slaves (1..16).
- AW, 32, address width.
- DW, 32, data width; wmask width is DW/8.
- SEL_MSB, 31, MSB of the slave-select field in the address.
- SEL_LSB, 28, LSB of the slave-select field; field width SW = SEL_MSB-SEL_LSB+1.
- TMO, 255, cycles allowed for a slave to accept a command; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- m_icb_cmd_valid  in  M_NUM  per-master command valid.
- m_icb_cmd_ready  out  M_NUM  per-master command ready.
- m_icb_cmd_addr  in  M_NUM*AW  packed, master i at [i*AW +: AW].
- m_icb_cmd_read  in  M_NUM  1 = read.
- m_icb_cmd_wdata  in  M_NUM*DW  packed write data.
- m_icb_cmd_wmask  in  M_NUM*DW/8  packed byte mask.
- m_icb_rsp_valid  out  M_NUM  per-master response valid.
- m_icb_rsp_ready  in  M_NUM  per-master response ready.
- m_icb_rsp_err  out  M_NUM  response error.
- m_icb_rsp_rdata  out  M_NUM*DW  packed read data.
- s_icb_cmd_valid  out  S_NUM  per-slave command valid.
- s_icb_cmd_ready  in  S_NUM  per-slave command ready.
- s_icb_cmd_addr  out  AW  shared, full address forwarded.
- s_icb_cmd_read  out  1  shared.
- s_icb_cmd_wdata  out  DW  shared.
- s_icb_cmd_wmask  out  DW/8  shared.
- s_icb_rsp_valid  in  S_NUM  per-slave response valid.
- s_icb_rsp_ready  out  S_NUM  per-slave response ready.
- s_icb_rsp_err  in  S_NUM  per-slave response error.
- s_icb_rsp_rdata  in  S_NUM*DW  packed per-slave read data.
- bus_busy  out  1  high whenever state != IDLE.
- tmo_pulse  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, rr_ptr=0, grant/sel/timer cleared.
  - All valid/ready outputs 0, rsp_err 0, rdata 0, bus_busy 0, tmo_pulse 0.
  - Any in-flight transaction is abandoned; no response is issued for it.
- States: IDLE, CMD, RSP, DERR, ERSP.
- IDLE:
  - If any m_cmd_valid is set, grant the first valid master searching upward from rr_ptr, modulo M_NUM.
  - Register gnt and sel = addr[SEL_MSB:SEL_LSB].
  - Next state is CMD if sel < S_NUM, else DERR.
  - No ready is asserted in IDLE, so arbitration costs 1 cycle.
- CMD:
  - Shared s_cmd_* are driven from master gnt; s_icb_cmd_valid[sel] = m_cmd_valid[gnt].
  - m_cmd_ready[gnt] = s_cmd_ready[sel]; all other readys are 0.
  - On handshake go to RSP. Masters must hold cmd stable until ready (ICB rule).
- Timeout (TMO>0):
  - Timer counts cycles in CMD.
  - When the timer reaches TMO without handshake: assert m_cmd_ready[gnt]=1 that cycle (command consumed), s_cmd_valid=0, tmo_pulse=1, go to ERSP.
- RSP:
  - m_rsp_valid[gnt] = s_rsp_valid[sel]; err and rdata are passed from slave sel.
  - s_rsp_ready[sel] = m_rsp_ready[gnt].
  - On handshake: rr_ptr = (gnt+1) mod M_NUM, go to IDLE. No timeout in RSP.
- DERR: m_cmd_ready[gnt]=1 for exactly one cycle, no slave valid, then ERSP.
- ERSP:
  - m_rsp_valid[gnt]=1, rsp_err=1, rdata=0.
  - On m_rsp_ready go to IDLE and update rr_ptr as in RSP.
- Fairness and widths:
  - Requests arriving while busy are ignored until IDLE.
  - Simultaneous requests resolve by rr_ptr; a master cannot win twice in a row while another requests.
  - Timer width is clog2(TMO+1) and saturates. Outputs for non-granted indices are always 0.
- Minimum transaction is 3 cycles (IDLE, CMD with ready=1, RSP with valid & ready=1).

Test Plan:
- Single read: M_NUM=2. M1 reads 0x2000_0010 and slave 2 returns rdata 0xDEADBEEF in the cycle after accept → M1 rdata 0xDEADBEEF, err=0, 3 cycles total; s_icb_cmd_valid only bit 2.
- Contention: M0 and M1 request continuously from reset → grants alternate 0,1,0,1; each master completes 4 transactions over 8 transfers.
- Decode miss: S_NUM=5, address 0x7000_0000 (sel=7) → m_cmd_ready pulses once, then rsp_err=1, rdata=0; no s_cmd_valid asserted.
- Timeout: TMO=4, slave 1 holds ready=0 → accept and tmo_pulse exactly 4 cycles after entering CMD; s_cmd_valid[1] drops; err response to the master.
- Backpressure: master holds rsp_ready=0 for 3 cycles → s_rsp_ready stays 0 and rdata is held stable; completes on the 4th cycle.
- Reset mid-RSP: assert rst while in RSP → next cycle all outputs 0, bus_busy=0; a fresh M0 write completes normally.
